// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event receiver.
// Event words pack {ext, brk, code} so the FIFO stores one flat vector per key event.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  localparam int EV_W        = 10;
  localparam int EV_CODE_LSB = 0;
  localparam int EV_CODE_W   = 8;
  localparam int EV_BRK_BIT  = 8;
  localparam int EV_EXT_BIT  = 9;

  // Odd parity over data+parity, and the stop bit must be high.
  function automatic logic frame_good(input logic [7:0] data, input logic parity,
                                      input logic stop);
    return (^{data, parity}) & stop;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame reception with inter-bit timeout.
// byte_valid / frame_err are registered one-cycle pulses; byte_data holds until the next frame.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic           clk_s1, clk_s2, data_s1, data_s2;
  logic [FCW-1:0] filt_cnt;
  logic           clk_f, clk_f_prev;
  logic           fall;
  logic [TCW-1:0] tmo_cnt;
  logic           timeout;

  frame_state_t   state_reg, state_next;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift_reg;
  logic           parity_reg;
  logic           byte_valid_reg, byte_valid_next;
  logic           frame_err_reg, frame_err_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Filtered clock only follows the synced pin after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt   <= '0;
      clk_f      <= 1'b1;
      clk_f_prev <= 1'b1;
    end else begin
      clk_f_prev <= clk_f;
      if (clk_s2 == clk_f) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        clk_f    <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall    = clk_f_prev & ~clk_f;
  assign timeout = (state_reg != ST_IDLE) && !fall && (tmo_cnt == TCW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (fall || state_reg == ST_IDLE || timeout) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (timeout) begin
      state_next = ST_IDLE;
    end else if (fall) begin
      case (state_reg)
        ST_IDLE:   if (!data_s2) state_next = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_next = ST_PARITY;
        ST_PARITY: state_next = ST_STOP;
        ST_STOP:   state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    byte_valid_next = 1'b0;
    frame_err_next  = timeout;
    if (fall && state_reg == ST_STOP) begin
      byte_valid_next = frame_good(shift_reg, parity_reg, data_s2);
      frame_err_next  = !frame_good(shift_reg, parity_reg, data_s2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt        <= '0;
      shift_reg      <= '0;
      parity_reg     <= 1'b0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      byte_valid_reg <= byte_valid_next;
      frame_err_reg  <= frame_err_next;
      if (fall) begin
        case (state_reg)
          ST_IDLE:   bit_cnt <= '0;
          ST_DATA: begin
            shift_reg <= {data_s2, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
          end
          ST_PARITY: parity_reg <= data_s2;
          default:   ;
        endcase
      end
    end
  end

  assign byte_valid = byte_valid_reg;
  assign byte_data  = shift_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: folds E0/F0 prefixes into key events and queues them in a
// show-ahead FIFO with valid/ready, plus sticky overflow and a saturating error counter.
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8,
  parameter int ERR_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_brk,
  output logic             frame_err,
  output logic             overflow,
  output logic [ERR_W-1:0] err_count,
  input  logic             clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            ext_pend, brk_pend;
  logic            ev_push;
  logic [EV_W-1:0] ev_word;

  logic [EV_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            empty, full, pop, wr_en, drop;
  logic [EV_W-1:0] head;
  logic            overflow_reg;
  logic [ERR_W-1:0] err_count_reg;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  always_comb begin
    ev_push = byte_valid && (byte_data != PS2_EXT_CODE) && (byte_data != PS2_BRK_CODE);
    ev_word = '0;
    ev_word[EV_CODE_LSB +: EV_CODE_W] = byte_data;
    ev_word[EV_BRK_BIT] = brk_pend;
    ev_word[EV_EXT_BIT] = ext_pend;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (frame_err) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_valid) begin
      if (byte_data == PS2_EXT_CODE) begin
        ext_pend <= 1'b1;
      end else if (byte_data == PS2_BRK_CODE) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  // The extra pointer MSB tells full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && ev_ready;
  assign wr_en = ev_push && (!full || pop);
  assign drop  = ev_push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= ev_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign head     = mem[rd_ptr[AW-1:0]];
  assign ev_valid = !empty;
  assign ev_code  = empty ? 8'h00 : head[EV_CODE_LSB +: EV_CODE_W];
  assign ev_ext   = empty ? 1'b0 : head[EV_EXT_BIT];
  assign ev_brk   = empty ? 1'b0 : head[EV_BRK_BIT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      err_count_reg <= '0;
    end else if (clr) begin
      overflow_reg  <= 1'b0;
      err_count_reg <= '0;
    end else begin
      if (drop) overflow_reg <= 1'b1;
      if (frame_err && (err_count_reg != {ERR_W{1'b1}})) err_count_reg <= err_count_reg + 1'b1;
    end
  end

  assign overflow  = overflow_reg;
  assign err_count = err_count_reg;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed + randomized bench for ps2_key_event_rx with a queue-based key event model.
module tb_ps2_key_event_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 1500;
  localparam int DEPTH      = 8;
  localparam int ERR_W      = 8;
  localparam int HALF       = 30;

  logic             clk = 1'b0;
  logic             rst, ps2_clk, ps2_data, ev_ready, clr;
  logic             ev_valid, ev_ext, ev_brk, frame_err, overflow;
  logic [7:0]       ev_code;
  logic [ERR_W-1:0] err_count;

  ps2_key_event_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT),
    .FIFO_DEPTH    (DEPTH),
    .ERR_W         (ERR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_brk   (ev_brk),
    .frame_err(frame_err),
    .overflow (overflow),
    .err_count(err_count),
    .clr      (clr)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  int         got_idx = 0;
  int         exp_idx = 0;
  int         err_pulses = 0;
  bit         m_ext, m_brk, m_ovf, m_stall;
  int         m_errs;

  // Consumer-side monitor: records every accepted event and every error pulse.
  always @(posedge clk) begin
    if (!rst) begin
      if (ev_valid && ev_ready) got_q.push_back({ev_ext, ev_brk, ev_code});
      if (frame_err) err_pulses++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: prefixes accumulate, any other byte becomes one event.
  task automatic m_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (m_stall && (exp_q.size() - exp_idx) >= DEPTH) m_ovf = 1'b1;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic m_err();
    m_ext = 1'b0;
    m_brk = 1'b0;
    if (m_errs < (1 << ERR_W) - 1) m_errs++;
  endtask

  // Sends the first nfall bits of a frame; glitch_bit >= 0 adds a short clock glitch in that bit.
  task automatic send(input logic [7:0] b, input bit flip, input int nfall, input int glitch_bit);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nfall; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        repeat (HALF / 2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - HALF / 2 - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic sendm(input logic [7:0] b);
    send(b, 1'b0, 11, -1);
    m_byte(b);
  endtask

  task automatic check_events(input string tag);
    int n_got, n_exp;
    repeat (5) @(negedge clk);
    n_got = got_q.size() - got_idx;
    n_exp = exp_q.size() - exp_idx;
    chk({tag, "_count"}, n_got, n_exp);
    for (int i = 0; i < n_exp && i < n_got; i++)
      chk({tag, "_event"}, got_q[got_idx + i], exp_q[exp_idx + i]);
    got_idx += n_got;
    exp_idx += n_exp;
  endtask

  initial begin
    int         ep0;
    logic [7:0] rb;
    int         r;
    logic       v [1:13];
    logic [7:0] code12;

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ev_ready = 1'b0; clr = 1'b0;
    m_ext = 0; m_brk = 0; m_ovf = 0; m_stall = 0; m_errs = 0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", ev_valid, 0);
    chk("rst_code", {ev_ext, ev_brk, ev_code}, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_frame_err", frame_err, 0);

    // Single make code 1D: ev_valid rises 2 cycles after the stop sample, lasts one cycle.
    ev_ready = 1'b1;
    send(8'h1D, 1'b0, 10, -1);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    code12 = 8'h00;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk);
      #1;
      v[k] = ev_valid;
      if (k == 12) code12 = ev_code;
    end
    chk("lat_before", v[FILTER_LEN + 3], 0);
    chk("lat_at", v[FILTER_LEN + 4], 1);
    chk("lat_after", v[FILTER_LEN + 5], 0);
    chk("lat_code", code12, 8'h1D);
    @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    m_byte(8'h1D);
    check_events("make_1d");

    sendm(8'hE0);
    sendm(8'hF0);
    sendm(8'h75);
    check_events("ext_brk_75");

    ep0 = err_pulses;
    send(8'h1C, 1'b1, 11, -1);
    m_err();
    check_events("bad_parity");
    chk("parity_err_pulses", err_pulses - ep0, 1);
    chk("parity_err_count", err_count, m_errs);
    sendm(8'h23);
    check_events("after_parity");

    ep0 = err_pulses;
    send(8'hAA, 1'b0, 6, -1);
    repeat (TIMEOUT + 100) @(negedge clk);
    m_err();
    chk("timeout_err_pulses", err_pulses - ep0, 1);
    chk("timeout_err_count", err_count, m_errs);
    sendm(8'h4B);
    check_events("after_timeout");

    ev_ready = 1'b0;
    m_stall = 1'b1;
    for (int i = 0; i <= DEPTH; i++) sendm(8'h10 + 8'(i));
    chk("ovf_set", overflow, m_ovf);
    chk("ovf_head_valid", ev_valid, 1);
    chk("ovf_head_code", ev_code, exp_q[exp_idx][7:0]);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    m_ovf = 0; m_errs = 0;
    chk("clr_overflow", overflow, m_ovf);
    chk("clr_err_count", err_count, m_errs);
    ev_ready = 1'b1;
    m_stall = 1'b0;
    repeat (20) @(negedge clk);
    check_events("drain");
    chk("drain_empty", ev_valid, 0);

    send(8'h5A, 1'b0, 11, 4);
    m_byte(8'h5A);
    check_events("glitch");

    for (int n = 0; n < 20; n++) begin
      r = int'($urandom_range(0, 9));
      rb = 8'($urandom_range(0, 255));
      if (r == 0) begin
        send(rb, 1'b1, 11, -1);
        m_err();
      end else if (r <= 2) begin
        sendm(8'hE0);
      end else if (r == 3) begin
        sendm(8'hF0);
      end else begin
        if (rb == 8'hE0 || rb == 8'hF0) rb = 8'h01;
        sendm(rb);
      end
    end
    check_events("random");
    chk("random_err_count", err_count, m_errs);

    sendm(8'hE0);
    send(8'h33, 1'b0, 4, -1);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk); rst = 1'b0;
    m_ext = 0; m_brk = 0; m_errs = 0; m_ovf = 0;
    @(negedge clk);
    chk("midrst_err_count", err_count, m_errs);
    chk("midrst_valid", ev_valid, 0);
    sendm(8'h33);
    check_events("after_midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_rx.md
Name: ps2_key_event_rx

Overview:
Parametrised PS/2 keyboard receiver, successor to the team's fixed-keymap PS/2 controller. Filters and synchronises the PS/2 lines and receives 11-bit frames with start, odd-parity and stop checking plus an inter-bit timeout. Folds E0 (extended) and F0 (break) prefixes into complete key events and buffers them in a show-ahead FIFO with a valid/ready interface. Sits between the board PS/2 pins and the game input logic, which maps scan codes to moves itself.

Parameters:
FILTER_LEN, 8, consecutive identical synced samples required before filtered ps2_clk changes (>=1)
TIMEOUT_CYCLES, 100000, clk cycles without a PS/2 falling edge before an in-progress frame is aborted (2 ms at 50 MHz)
FIFO_DEPTH, 8, event FIFO entries (power of two, >=2)
ERR_W, 8, width of the saturating error counter

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  reset, asynchronous, active-high
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
ev_valid  out  1  FIFO non-empty; head event presented
ev_ready  in  1  consumer accepts head event when ev_valid=1
ev_code  out  8  scan code of head event
ev_ext  out  1  head event was preceded by E0
ev_brk  out  1  head event was preceded by F0 (key release)
frame_err  out  1  one-cycle pulse on any parity, stop or timeout error
overflow  out  1  sticky: an event was dropped because the FIFO was full
err_count  out  ERR_W  saturating count of frame_err pulses
clr  in  1  synchronous clear of overflow and err_count

Behaviour:
- Reset: all outputs 0. Sync/filter flops to 1. FSM to IDLE. Prefix flags, FIFO pointers and timeout counter to 0.
- Input conditioning: each pin goes through a 2-flop synchroniser. Filtered clock clk_f takes the synced value only after FILTER_LEN equal consecutive samples. fall = clk_f_prev & ~clk_f (one-cycle pulse). ps2_data is sampled (synced) on fall.
- Frame FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on fall, except timeout.
  - IDLE: data=0 -> DATA with bit counter 0. data=1 -> stay, no error.
  - DATA: shift data in LSB first. After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: good frame if XOR(8 data bits, parity)=1 and data=1. Good frame -> byte_valid pulse next cycle. Otherwise -> frame_err pulse next cycle. Either way -> IDLE.
- Timeout: counter clears on every fall and while in IDLE. In any non-IDLE state, reaching TIMEOUT_CYCLES-1 forces IDLE and pulses frame_err. A fall in the same cycle as the threshold wins; no timeout.
- Prefix decode on byte_valid:
  - E0 sets ext_pend.
  - F0 sets brk_pend.
  - Any other byte produces event {ext_pend, brk_pend, byte} and clears both flags.
  - frame_err clears both flags.
- FIFO: write one cycle after byte_valid. Latency: stop bit sampled on cycle N gives ev_valid=1 after edge N+2 when the FIFO was empty.
  - Pop on ev_valid & ev_ready.
  - Push when full is accepted only if a pop happens in the same cycle. Otherwise the event is dropped and overflow is set.
  - ev_code/ev_ext/ev_brk are forced to 0 when empty.
  - Pointers wrap modulo FIFO_DEPTH. A full/empty distinction bit is required.
- err_count increments on frame_err and saturates at all-ones. clr has priority over a simultaneous increment or overflow set.
- rst mid-frame: the partial frame and pending prefixes are discarded. The next frame is received normally after a falling edge with a start bit.

Decomposition:
- Package ps2_pkg:
  - PS2_EXT_CODE=8'hE0, PS2_BRK_CODE=8'hF0
  - frame state enum
  - event width constant (10) with field offsets
- Sub-module ps2_frame_rx: synchroniser, filter, frame FSM and timeout. Outputs byte_valid, byte_data and frame_err.
- Top level holds the prefix decoder, FIFO and counters.

Test Plan:
- Frame 0x1D with correct parity, ev_ready=1 -> exactly one event: code=1D, ext=0, brk=0; ev_valid high for one cycle, 2 cycles after the stop sample.
- Bytes E0,F0,75 (extended up-arrow release) -> single event: code=75, ext=1, brk=1; the prefixes produce no events.
- Frame 0x1C with a flipped parity bit -> no event, one frame_err pulse, err_count=1. A following 0x23 is received correctly.
- Stop after 5 data bits; wait TIMEOUT_CYCLES -> frame_err, FSM IDLE. A following full frame 0x4B gives event code=4B.
- ev_ready=0, send FIFO_DEPTH+1 make codes -> first 8 retained in order, overflow=1. Pulse clr -> overflow=0. Drain -> 8 events, then ev_valid=0.
- 2-cycle glitch on ps2_clk (shorter than FILTER_LEN) mid-frame -> no extra bit shifted; the byte is received intact.
